// File: rtl/user_tx_arbiter_pkg.sv
// Types shared by the TX arbiter and the RX demux: router address, local user IDs,
// and the arbiter FSM state encoding.
package user_tx_arbiter_pkg;

    localparam int ROUTER_ADDR_WIDTH = 16;
    typedef logic [ROUTER_ADDR_WIDTH-1:0] router_addr_t;

    localparam int USER_ID_WIDTH = 4;
    localparam logic [USER_ID_WIDTH-1:0] CONTROLLER_ID = 4'hF;
    typedef logic [USER_ID_WIDTH-1:0] user_id_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_e;

    // Slot 0 is the controller; user engines occupy slots 1.. and report ID slot-1.
    function automatic user_id_t slot_to_user_id(input int unsigned slot);
        return (slot == 0) ? CONTROLLER_ID : user_id_t'(slot - 1);
    endfunction

endpackage

// File: rtl/user_tx_arbiter_if.sv
// TX channel bundle: per-slot request side from the user engines and the single
// muxed side toward the layer packetizer. master = arbiter view, slave = environment view.
interface user_tx_arbiter_if #(
    parameter int NUM_USERS     = 4,
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 16,
    parameter int META_WIDTH    = 32,
    parameter int USER_ID_WIDTH = 4
);
    logic [NUM_USERS*DATA_WIDTH-1:0] users_tx_data;
    logic [NUM_USERS-1:0]            users_tx_valid;
    logic [NUM_USERS-1:0]            users_tx_last;
    logic [NUM_USERS*ADDR_WIDTH-1:0] users_tx_dest;
    logic [NUM_USERS*META_WIDTH-1:0] users_tx_meta;
    logic [NUM_USERS-1:0]            users_tx_ready;

    logic [DATA_WIDTH-1:0]           layer_tx_data;
    logic                            layer_tx_valid;
    logic                            layer_tx_last;
    logic [ADDR_WIDTH-1:0]           layer_tx_dest;
    logic [META_WIDTH-1:0]           layer_tx_meta;
    logic [USER_ID_WIDTH-1:0]        layer_tx_src_user;
    logic                            layer_tx_ready;

    modport master (
        input  users_tx_data, users_tx_valid, users_tx_last, users_tx_dest, users_tx_meta,
        output users_tx_ready,
        output layer_tx_data, layer_tx_valid, layer_tx_last, layer_tx_dest, layer_tx_meta,
        output layer_tx_src_user,
        input  layer_tx_ready
    );

    modport slave (
        output users_tx_data, users_tx_valid, users_tx_last, users_tx_dest, users_tx_meta,
        input  users_tx_ready,
        input  layer_tx_data, layer_tx_valid, layer_tx_last, layer_tx_dest, layer_tx_meta,
        input  layer_tx_src_user,
        output layer_tx_ready
    );

endinterface

// File: rtl/user_tx_arbiter_rr_pick.sv
// Round-robin first-one finder: first set request scanning upward from last_grant+1,
// wrapping modulo NUM_USERS.
module user_tx_arbiter_rr_pick #(
    parameter int NUM_USERS = 4,
    parameter int IDX_W     = $clog2(NUM_USERS)
) (
    input  logic [NUM_USERS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     idx_o
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_USERS);

    logic [IDX_W:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_USERS; k++) begin
            cand = {1'b0, last_grant_i} + (IDX_W+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found_o && req_i[cand[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/user_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the layer TX channel between the
// controller (slot 0) and the user engines; tags each packet with the sender's local ID.
//
//   state | meaning
//   IDLE  | no grant held; arbitrate among valid slots, register winner
//   BUSY  | channel owned by slot grant_q until its last beat is accepted
module user_tx_arbiter
    import user_tx_arbiter_pkg::*;
#(
    parameter int NUM_USERS     = 4,
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 16,
    parameter int META_WIDTH    = 32,
    parameter int USER_ID_WIDTH = user_tx_arbiter_pkg::USER_ID_WIDTH,
    parameter logic [USER_ID_WIDTH-1:0] CONTROLLER_ID = user_tx_arbiter_pkg::CONTROLLER_ID
) (
    input  logic              clk,
    input  logic              rst_n,
    user_tx_arbiter_if.master tx_if,
    output logic [31:0]       tx_packet_count,
    output logic [31:0]       tx_beat_count
);

    localparam int IDX_W = $clog2(NUM_USERS);
    localparam logic [0:0] ST_IDLE = TX_IDLE;
    localparam logic [0:0] ST_BUSY = TX_BUSY;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [31:0]      pkt_cnt_q, beat_cnt_q;

    logic [DATA_WIDTH-1:0] data_a [NUM_USERS];
    logic [ADDR_WIDTH-1:0] dest_a [NUM_USERS];
    logic [META_WIDTH-1:0] meta_a [NUM_USERS];

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             busy, hs, pkt_done;

    for (genvar i = 0; i < NUM_USERS; i++) begin : g_slot
        assign data_a[i] = tx_if.users_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign dest_a[i] = tx_if.users_tx_dest[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign meta_a[i] = tx_if.users_tx_meta[i*META_WIDTH +: META_WIDTH];
    end

    user_tx_arbiter_rr_pick #(
        .NUM_USERS (NUM_USERS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req_i        (tx_if.users_tx_valid),
        .last_grant_i (last_grant_q),
        .found_o      (pick_found),
        .idx_o        (pick_idx)
    );

    assign busy     = (state_q == ST_BUSY);
    assign hs       = tx_if.layer_tx_valid & tx_if.layer_tx_ready;
    assign pkt_done = hs & tx_if.layer_tx_last;

    // Datapath follows grant_q even in IDLE so the mux select never toggles on its own.
    assign tx_if.layer_tx_data     = data_a[grant_q];
    assign tx_if.layer_tx_dest     = dest_a[grant_q];
    assign tx_if.layer_tx_meta     = meta_a[grant_q];
    assign tx_if.layer_tx_last     = tx_if.users_tx_last[grant_q];
    assign tx_if.layer_tx_valid    = busy & tx_if.users_tx_valid[grant_q];
    assign tx_if.layer_tx_src_user = (grant_q == '0) ? CONTROLLER_ID
                                   : USER_ID_WIDTH'(grant_q) - USER_ID_WIDTH'(1);
    assign tx_if.users_tx_ready    = busy ? (NUM_USERS'(tx_if.layer_tx_ready) << grant_q)
                                          : '0;

    assign tx_packet_count = pkt_cnt_q;
    assign tx_beat_count   = beat_cnt_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (pkt_done) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_USERS - 1);
            pkt_cnt_q    <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            if (hs) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
            if (pkt_done) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_user_tx_arbiter.sv
// Scoreboard bench for user_tx_arbiter: per-slot beat queues drive the engines,
// expected layer beats are queued in predicted grant order and popped on each handshake.
module tb_user_tx_arbiter;
    import user_tx_arbiter_pkg::*;

    localparam int NU = 4;
    localparam int DW = 512;
    localparam int AW = 16;
    localparam int MW = 32;

    typedef struct {
        logic          v;
        logic [DW-1:0] data;
        logic          last;
        logic [AW-1:0] dest;
        logic [MW-1:0] meta;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [AW-1:0] dest;
        logic [MW-1:0] meta;
        logic [3:0]    src;
        int            slot;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tx_packet_count;
    logic [31:0] tx_beat_count;

    int errors    = 0;
    int checks    = 0;
    int bad_ready = 0;
    int cyc       = 0;

    beat_t          slot_q [NU][$];
    exp_t           sb[$];
    int             hs_cyc[$];
    logic [NU-1:0]  took = '0;
    exp_t           mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    user_tx_arbiter_if #(
        .NUM_USERS(NU), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .META_WIDTH(MW), .USER_ID_WIDTH(4)
    ) tx_if ();

    user_tx_arbiter #(
        .NUM_USERS(NU), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .META_WIDTH(MW),
        .USER_ID_WIDTH(4), .CONTROLLER_ID(4'hF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tx_if           (tx_if),
        .tx_packet_count (tx_packet_count),
        .tx_beat_count   (tx_beat_count)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NU; i++) if (slot_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Queue a packet on a slot and append its beats to the expected layer stream.
    task automatic send_pkt(input int slot, input int nbeats, input int hole_after = 0,
                            input int hole_len = 0);
        beat_t bt;
        exp_t  e;
        for (int b = 0; b < nbeats; b++) begin
            bt.v    = 1'b1;
            bt.data = rnd_data();
            bt.last = (b == nbeats - 1);
            bt.dest = AW'($urandom);
            bt.meta = MW'($urandom);
            slot_q[slot].push_back(bt);
            e.data = bt.data;
            e.last = bt.last;
            e.dest = bt.dest;
            e.meta = bt.meta;
            e.src  = (slot == 0) ? 4'hF : 4'(slot - 1);
            e.slot = slot;
            sb.push_back(e);
            if (b + 1 == hole_after) begin
                for (int h = 0; h < hole_len; h++) begin
                    bt = '{v: 1'b0, data: '0, last: 1'b0, dest: '0, meta: '0};
                    slot_q[slot].push_back(bt);
                end
            end
        end
    endtask

    task automatic present(input int i);
        if (slot_q[i].size() != 0 && slot_q[i][0].v) begin
            tx_if.users_tx_valid[i]         = 1'b1;
            tx_if.users_tx_last[i]          = slot_q[i][0].last;
            tx_if.users_tx_data[i*DW +: DW] = slot_q[i][0].data;
            tx_if.users_tx_dest[i*AW +: AW] = slot_q[i][0].dest;
            tx_if.users_tx_meta[i*MW +: MW] = slot_q[i][0].meta;
        end else begin
            tx_if.users_tx_valid[i] = 1'b0;
            tx_if.users_tx_last[i]  = 1'b0;
        end
    endtask

    // Engine models: drop an accepted beat or an elapsed idle slot, then present the next.
    initial begin
        tx_if.users_tx_valid = '0;
        tx_if.users_tx_last  = '0;
        tx_if.users_tx_data  = '0;
        tx_if.users_tx_dest  = '0;
        tx_if.users_tx_meta  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NU; i++) begin
                if (slot_q[i].size() != 0 && (!slot_q[i][0].v || took[i]))
                    void'(slot_q[i].pop_front());
                present(i);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            took = '0;
        end else begin
            for (int i = 0; i < NU; i++)
                if (tx_if.users_tx_ready[i] && (sb.size() == 0 || sb[0].slot != i)) bad_ready++;
            took = tx_if.users_tx_valid & tx_if.users_tx_ready;
            if (tx_if.layer_tx_valid && tx_if.layer_tx_ready) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check_val("unexpected_beat", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("beat_data", tx_if.layer_tx_data, mon_e.data);
                    check_val("beat_last", tx_if.layer_tx_last, mon_e.last);
                    check_val("beat_dest", tx_if.layer_tx_dest, mon_e.dest);
                    check_val("beat_meta", tx_if.layer_tx_meta, mon_e.meta);
                    check_val("beat_src",  tx_if.layer_tx_src_user, mon_e.src);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tx_if.layer_tx_ready = 1'b1;
        for (int i = 0; i < NU; i++) slot_q[i].delete();
        sb.delete();
        took = '0;
        repeat (2) @(negedge clk);
        check_val("rst_valid", tx_if.layer_tx_valid, 0);
        check_val("rst_ready", tx_if.users_tx_ready, 0);
        check_val("rst_pkt",   tx_packet_count, 0);
        check_val("rst_beat",  tx_beat_count, 0);
        rst_n = 1'b1;
        hs_cyc.delete();
        bad_ready = 0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || pending()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_drain"}, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_hs(input string tag, input int nhs, input int budget);
        int n = 0;
        while (hs_cyc.size() < nhs && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val({tag, "_wait_hs"}, hs_cyc.size() >= nhs, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        tx_if.layer_tx_ready = 1'b1;

        // 1: single 3-beat packet from slot 2, latency and counters
        do_reset();
        c0 = cyc + 1;
        send_pkt(2, 3);
        wait_drain("t1", 50);
        check_val("t1_nbeats", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check_val("t1_first_cyc", hs_cyc[0], c0 + 1);
            check_val("t1_last_cyc",  hs_cyc[2], c0 + 3);
        end
        check_val("t1_pkt",  tx_packet_count, 1);
        check_val("t1_beat", tx_beat_count, 3);
        check_val("t1_bad_ready", bad_ready, 0);

        // 2: all slots stream 1-beat packets; order 0,1,2,3,0,1 with one bubble each
        do_reset();
        send_pkt(0, 1); send_pkt(1, 1); send_pkt(2, 1);
        send_pkt(3, 1); send_pkt(0, 1); send_pkt(1, 1);
        wait_drain("t2", 100);
        check_val("t2_nbeats", hs_cyc.size(), 6);
        for (int k = 1; k < hs_cyc.size(); k++)
            check_val("t2_gap", hs_cyc[k] - hs_cyc[k-1], 2);
        check_val("t2_pkt", tx_packet_count, 6);
        check_val("t2_bad_ready", bad_ready, 0);

        // 3: layer stall mid-packet with a competing requester
        do_reset();
        send_pkt(1, 4);
        wait_hs("t3", 1, 50);
        @(posedge clk);
        #2;
        tx_if.layer_tx_ready = 1'b0;
        send_pkt(3, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("t3_hold_valid", tx_if.layer_tx_valid, 1);
            check_val("t3_hold_data",  tx_if.layer_tx_data, sb[0].data);
            check_val("t3_hold_beat",  tx_beat_count, 1);
            check_val("t3_hold_pkt",   tx_packet_count, 0);
            check_val("t3_ready3",     tx_if.users_tx_ready[3], 0);
        end
        @(posedge clk);
        #2;
        tx_if.layer_tx_ready = 1'b1;
        wait_drain("t3", 100);
        check_val("t3_pkt",  tx_packet_count, 2);
        check_val("t3_beat", tx_beat_count, 5);
        check_val("t3_bad_ready", bad_ready, 0);

        // 4: granted slot drops valid mid-packet; no interleave
        do_reset();
        send_pkt(0, 4, 2, 2);
        send_pkt(2, 2);
        wait_drain("t4", 100);
        check_val("t4_pkt",  tx_packet_count, 2);
        check_val("t4_beat", tx_beat_count, 6);
        check_val("t4_bad_ready", bad_ready, 0);

        // 5: async reset on beat 2; slot 0 wins first after release
        do_reset();
        send_pkt(3, 4);
        wait_hs("t5", 1, 50);
        @(posedge clk);
        #3;
        check_val("t5_pre_valid", tx_if.layer_tx_valid, 1);
        rst_n = 1'b0;
        #1;
        check_val("t5_async_valid", tx_if.layer_tx_valid, 0);
        check_val("t5_async_ready", tx_if.users_tx_ready, 0);
        for (int i = 0; i < NU; i++) slot_q[i].delete();
        sb.delete();
        took = '0;
        send_pkt(0, 1);
        send_pkt(3, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bad_ready = 0;
        wait_drain("t5", 50);
        check_val("t5_pkt",  tx_packet_count, 2);
        check_val("t5_beat", tx_beat_count, 2);
        check_val("t5_bad_ready", bad_ready, 0);

        // 6: packet counter wraps
        do_reset();
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_q;
        check_val("t6_preload", tx_packet_count, 32'hFFFF_FFFF);
        send_pkt(1, 1);
        send_pkt(2, 1);
        wait_drain("t6", 50);
        check_val("t6_pkt_wrap", tx_packet_count, 1);
        check_val("t6_beat", tx_beat_count, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
